fifo_rr_arbiter: RTL and testbench

Round-robin arbiter that drains four source FIFOs (6-bit words) and routes each word to one of four destination FIFOs selected by the word's two MSBs. It drives the sources' `pop` and the destinations' `push` and `Fifo_Data_in`, and honours destination backpressure (`Pausa`/`Fifo_Full`). Per-destination delivery counters are exposed for the test bench and for debug. It sits between the input FIFO bank and the output FIFO bank of the switching datapath.

---
 rtl/fifo_rr_arbiter.sv | 74 +++++++
 tb/tb_fifo_rr_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin drain of four source FIFOs into four destination FIFOs with backpressure
module fifo_rr_arbiter #(
   parameter int DATA_WIDTH = 6,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                    clk,
   input  logic                    reset_L,
   input  logic [3:0]              src_empty,
   input  logic [4*DATA_WIDTH-1:0] src_data,
   input  logic [3:0]              dst_pause,
   input  logic [3:0]              dst_full,
   input  logic [1:0]              cnt_sel,
   output logic [3:0]              pop,
   output logic [3:0]              push,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic [1:0]              state,
   output logic                    idle,
   output logic [CNT_WIDTH-1:0]    cnt_out
);
   typedef enum logic [1:0] {RESET = 2'd0, INIT = 2'd1, IDLE = 2'd2, ACTIVE = 2'd3} state_t;
   state_t st, st_nxt;
   logic [DATA_WIDTH-1:0] word [4];
   logic [CNT_WIDTH-1:0] cnt [4];
   logic [3:0] elig;
   logic [1:0] rr_ptr, idx, win, win_dst;
   logic found;
   assign state = st;
   // a source whose pop is high still shows its old head, so it sits out one cycle
   for (genvar i = 0; i < 4; i++) begin : g_src
      assign word[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
      assign elig[i] = st == ACTIVE && !src_empty[i] && !pop[i]
                       && !dst_pause[word[i][DATA_WIDTH-1 -: 2]] && !dst_full[word[i][DATA_WIDTH-1 -: 2]];
   end
   always_comb begin
      st_nxt = st == RESET ? INIT :
               st == INIT  ? IDLE :
               st == IDLE  ? (&src_empty ? IDLE : ACTIVE) :
                             ((&src_empty && pop == 4'b0) ? IDLE : ACTIVE);
      found = 1'b0;
      win = '0;
      idx = rr_ptr;
      for (int k = 0; k < 4; k++) begin
         idx = rr_ptr + 2'(k);
         if (!found && elig[idx]) begin
            found = 1'b1;
            win = idx;
         end
      end
      win_dst = word[win][DATA_WIDTH-1 -: 2];
   end
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         st <= RESET;
         pop <= '0;
         push <= '0;
         data_out <= '0;
         idle <= 1'b0;
         cnt_out <= '0;
         rr_ptr <= '0;
         for (int j = 0; j < 4; j++) cnt[j] <= '0;
      end else begin
         st <= st_nxt;
         idle <= st_nxt == IDLE;
         cnt_out <= cnt[cnt_sel];
         pop <= found ? 4'b1 << win : 4'b0;
         push <= found ? 4'b1 << win_dst : 4'b0;
         if (found) begin
            data_out <= word[win];
            rr_ptr <= win + 2'd1;
            cnt[win_dst] <= cnt[win_dst] + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: queue-based source FIFOs and a behavioural model of the arbiter's rules
module tb_fifo_rr_arbiter;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_L = 1'b0;
   logic [3:0] src_empty, dst_pause = '0, dst_full = '0;
   logic [23:0] src_data;
   logic [1:0] cnt_sel = '0;
   logic [3:0] pop, push;
   logic [5:0] data_out;
   logic [1:0] state;
   logic idle;
   logic [4:0] cnt_out;
   int errors = 0, checks = 0;
   logic [5:0] srcq [4][$];
   logic [1:0] m_state = '0;
   logic [3:0] m_pop = '0, m_push = '0;
   logic [5:0] m_data = '0;
   logic m_idle = 1'b0;
   logic [4:0] m_cnt [4] = '{5'd0, 5'd0, 5'd0, 5'd0};
   logic [4:0] m_cnt_out = '0;
   int m_rr = 0;

   fifo_rr_arbiter dut (
      .clk(clk), .reset_L(reset_L), .src_empty(src_empty), .src_data(src_data),
      .dst_pause(dst_pause), .dst_full(dst_full), .cnt_sel(cnt_sel),
      .pop(pop), .push(push), .data_out(data_out), .state(state), .idle(idle), .cnt_out(cnt_out)
   );

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         src_empty[i] = srcq[i].size() == 0;
         src_data[i*6 +: 6] = srcq[i].size() > 0 ? srcq[i][0] : 6'($urandom);
      end
   endtask

   // one clock edge: predict from pre-edge inputs, let the source FIFOs pop, then settle at negedge
   task automatic tick();
      logic [3:0] old_pop;
      logic [5:0] w;
      logic [1:0] ns;
      int win, i, d;
      bit all_empty;
      old_pop = m_pop;
      all_empty = 1;
      for (int s = 0; s < 4; s++) if (srcq[s].size() > 0) all_empty = 0;
      if (!reset_L) begin
         m_state = 0; m_pop = 0; m_push = 0; m_data = 0; m_idle = 0; m_cnt_out = 0; m_rr = 0;
         for (int s = 0; s < 4; s++) m_cnt[s] = 0;
      end else begin
         m_cnt_out = m_cnt[cnt_sel];
         win = -1;
         if (m_state == 3)
            for (int k = 0; k < 4; k++) begin
               i = (m_rr + k) % 4;
               if (win < 0 && srcq[i].size() > 0 && !old_pop[i]) begin
                  w = srcq[i][0];
                  d = int'(w[5:4]);
                  if (!dst_pause[d] && !dst_full[d]) win = i;
               end
            end
         if (m_state == 0) ns = 1;
         else if (m_state == 1) ns = 2;
         else if (m_state == 2) ns = all_empty ? 2'd2 : 2'd3;
         else ns = (all_empty && old_pop == 0) ? 2'd2 : 2'd3;
         m_pop = 0;
         m_push = 0;
         if (win >= 0) begin
            w = srcq[win][0];
            m_pop[win] = 1'b1;
            m_push[w[5:4]] = 1'b1;
            m_data = w;
            m_rr = (win + 1) % 4;
            m_cnt[w[5:4]] = m_cnt[w[5:4]] + 5'd1;
         end
         m_state = ns;
         m_idle = ns == 2;
      end
      @(posedge clk);
      #1;
      for (int s = 0; s < 4; s++) if (old_pop[s] && srcq[s].size() > 0) void'(srcq[s].pop_front());
      drive();
      @(negedge clk);
   endtask

   task automatic reset_to();
      reset_L = 1'b0;
      dst_pause = '0;
      dst_full = '0;
      cnt_sel = '0;
      tick();
      for (int s = 0; s < 4; s++) srcq[s].delete();
      drive();
      tick();
   endtask

   task automatic test_reset();
      logic [5:0] heads [4] = '{6'h05, 6'h1A, 6'h2B, 6'h3C};
      reset_to();
      for (int s = 0; s < 4; s++) srcq[s].push_back(heads[s]);
      drive();
      repeat (3) begin
         tick();
         checks++; if (pop !== 4'b0 || push !== 4'b0) begin errors++; $display("FAIL reset_popush: pop=%b push=%b want 0", pop, push); end
         checks++; if (data_out !== 6'h0) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
         checks++; if (state !== 2'd0 || idle !== 1'b0 || cnt_out !== 5'd0) begin errors++; $display("FAIL reset_state: state=%0d idle=%b cnt_out=%0d want 0/0/0", state, idle, cnt_out); end
      end
      reset_L = 1'b1;
      for (int n = 1; n <= 3; n++) begin
         tick();
         checks++; if (state !== 2'(n)) begin errors++; $display("FAIL reset_seq: state=%0d want %0d", state, n); end
         checks++; if (idle !== (n == 2)) begin errors++; $display("FAIL reset_idle: idle=%b want %b", idle, n == 2); end
      end
   endtask

   task automatic test_rotation();
      logic [5:0] heads [4] = '{6'h05, 6'h1A, 6'h2B, 6'h3C};
      int s;
      reset_to();
      for (int i = 0; i < 4; i++) repeat (2) srcq[i].push_back(heads[i]);
      drive();
      reset_L = 1'b1;
      repeat (3) tick();
      for (int n = 0; n < 5; n++) begin
         tick();
         s = n % 4;
         checks++; if (pop !== 4'(1 << s)) begin errors++; $display("FAIL rot_pop%0d: got %b want %b", n, pop, 4'(1 << s)); end
         checks++; if (push !== 4'(1 << heads[s][5:4])) begin errors++; $display("FAIL rot_push%0d: got %b want %b", n, push, 4'(1 << heads[s][5:4])); end
         checks++; if (data_out !== heads[s]) begin errors++; $display("FAIL rot_data%0d: got %h want %h", n, data_out, heads[s]); end
      end
   endtask

   task automatic test_backpressure();
      reset_to();
      srcq[2].push_back(6'h21);
      dst_pause = 4'b0100;
      drive();
      reset_L = 1'b1;
      repeat (3) tick();
      repeat (4) begin
         tick();
         checks++; if (pop !== 4'b0 || push !== 4'b0) begin errors++; $display("FAIL bp_block: pop=%b push=%b want 0", pop, push); end
      end
      dst_pause = 4'b0000;
      tick();
      checks++; if (pop !== 4'b0100 || push !== 4'b0100) begin errors++; $display("FAIL bp_release: pop=%b push=%b want 0100/0100", pop, push); end
      checks++; if (data_out !== 6'h21) begin errors++; $display("FAIL bp_data: got %h want 21", data_out); end
   endtask

   task automatic test_single_rate();
      bit pat [7] = '{1, 0, 1, 0, 1, 0, 0};
      reset_to();
      srcq[1].push_back(6'h10); srcq[1].push_back(6'h11); srcq[1].push_back(6'h12);
      drive();
      reset_L = 1'b1;
      repeat (3) tick();
      for (int n = 0; n < 7; n++) begin
         tick();
         checks++; if (pop !== {2'b0, pat[n], 1'b0}) begin errors++; $display("FAIL rate_pop%0d: got %b want %b", n, pop, {2'b0, pat[n], 1'b0}); end
      end
      checks++; if (state !== 2'd2 || idle !== 1'b1) begin errors++; $display("FAIL rate_idle: state=%0d idle=%b want 2/1", state, idle); end
   endtask

   task automatic test_counter_wrap();
      int budget = 200;
      bit busy;
      reset_to();
      for (int n = 0; n < 33; n++) srcq[n % 4].push_back(6'h30 | 6'($urandom_range(0, 15)));
      drive();
      reset_L = 1'b1;
      repeat (3) tick();
      busy = 1;
      while (busy && budget > 0) begin
         tick();
         budget--;
         busy = state != 2'd2;
         checks++; if (push !== m_push || pop !== m_pop) begin errors++; $display("FAIL wrap_flow: pop=%b push=%b want %b/%b", pop, push, m_pop, m_push); end
      end
      checks++; if (busy) begin errors++; $display("FAIL wrap_timeout: state=%0d want 2", state); end
      cnt_sel = 2'd3;
      tick();
      checks++; if (cnt_out !== 5'd1) begin errors++; $display("FAIL wrap_cnt3: got %0d want 1", cnt_out); end
      cnt_sel = 2'd0;
      tick();
      checks++; if (cnt_out !== 5'd0) begin errors++; $display("FAIL wrap_cnt0: got %0d want 0", cnt_out); end
   endtask

   task automatic test_reset_mid();
      int budget = 20;
      reset_to();
      for (int s = 0; s < 4; s++) repeat (3) srcq[s].push_back(6'($urandom));
      drive();
      reset_L = 1'b1;
      repeat (3) tick();
      while (push == 4'b0 && budget > 0) begin tick(); budget--; end
      checks++; if (push == 4'b0) begin errors++; $display("FAIL mid_nopush: push=%b want nonzero", push); end
      reset_L = 1'b0;
      tick();
      checks++; if (push !== 4'b0 || pop !== 4'b0 || state !== 2'd0 || data_out !== 6'h0) begin errors++; $display("FAIL mid_reset: push=%b pop=%b state=%0d data=%h want 0", push, pop, state, data_out); end
      for (int s = 0; s < 4; s++) srcq[s].delete();
      drive();
      reset_L = 1'b1;
      for (int s = 0; s < 4; s++) begin
         cnt_sel = 2'(s);
         tick();
         checks++; if (cnt_out !== 5'd0) begin errors++; $display("FAIL mid_cnt%0d: got %0d want 0", s, cnt_out); end
      end
      srcq[3].push_back(6'h00);
      srcq[0].push_back(6'h00);
      drive();
      budget = 6;
      while (pop == 4'b0 && budget > 0) begin tick(); budget--; end
      checks++; if (pop !== 4'b0001) begin errors++; $display("FAIL mid_rr: first pop=%b want 0001", pop); end
   endtask

   task automatic test_random();
      reset_to();
      reset_L = 1'b1;
      for (int n = 0; n < 600; n++) begin
         for (int s = 0; s < 4; s++)
            if (srcq[s].size() < 4 && $urandom_range(0, 3) == 0) srcq[s].push_back(6'($urandom));
         dst_pause = 4'($urandom) & 4'($urandom) & 4'($urandom);
         dst_full = 4'($urandom) & 4'($urandom) & 4'($urandom);
         cnt_sel = 2'($urandom);
         reset_L = $urandom_range(0, 99) != 0;
         drive();
         tick();
         checks++; if (pop !== m_pop) begin errors++; $display("FAIL rnd_pop@%0d: got %b want %b", n, pop, m_pop); end
         checks++; if (push !== m_push) begin errors++; $display("FAIL rnd_push@%0d: got %b want %b", n, push, m_push); end
         checks++; if (data_out !== m_data) begin errors++; $display("FAIL rnd_data@%0d: got %h want %h", n, data_out, m_data); end
         checks++; if (state !== m_state) begin errors++; $display("FAIL rnd_state@%0d: got %0d want %0d", n, state, m_state); end
         checks++; if (idle !== m_idle) begin errors++; $display("FAIL rnd_idle@%0d: got %b want %b", n, idle, m_idle); end
         checks++; if (cnt_out !== m_cnt_out) begin errors++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", n, cnt_out, m_cnt_out); end
      end
   endtask

   initial begin
      for (int s = 0; s < 4; s++) srcq[s].delete();
      drive();
      test_reset();
      test_rotation();
      test_backpressure();
      test_single_rate();
      test_counter_wrap();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
